// File: rtl/keyboard_pkg.sv
// Shared types and constants for the PS/2 keyboard transmit/receive path.
//
// Contents:
//   tx_state_t          host-to-device transmitter FSM states
//   CMD_*               host command bytes
//   RSP_*               device response bytes
//   TX_LAST_BIT         bit counter value of the stop bit within the frame
//   odd_parity()        PS/2 frame parity for a data byte
package keyboard_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StShift,
        StAck,
        StWaitIdle,
        StDone
    } tx_state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;

    // Frame after the start bit is 8 data, parity, stop; index 9 is the stop bit.
    localparam logic [3:0] TX_LAST_BIT  = 4'd9;

    // Parity bit that makes the total count of ones (data + parity) odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/keyboard_tx_ps2_sync.sv
// Two-flop synchronizer plus falling-edge detector for one PS/2 line.
//
// Ports:
//   clock   system clock
//   resetn  synchronous active-low reset
//   pin     raw asynchronous line
//   level   synchronized line level
//   fall    high for one cycle when the synchronized level goes 1 -> 0
module ps2_sync (
    input  logic clock,
    input  logic resetn,
    input  logic pin,
    output logic level,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Reset to 1 (idle bus) so leaving reset never looks like a falling edge.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= pin;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/keyboard_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte to the keyboard.
// Inhibits the bus, issues request-to-send, shifts data/parity/stop on
// device clock falling edges, samples the device ACK and reports the result.
//
// Parameters:
//   INHIBIT_CYCLES  cycles the clock is held low before request-to-send
//   TIMEOUT_CYCLES  max cycles from clock release to the end of the frame
//
// Ports:
//   clock, resetn   system clock, synchronous active-low reset
//   send, cmd       start request and command byte (sampled in idle only)
//   busy            transfer in progress
//   done, ack_err   one-cycle completion pulse; ack_err=1 on NACK or timeout
//   ps2_clk_in      raw PS/2 clock pin
//   ps2_data_in     raw PS/2 data pin
//   ps2_clk_oe      1 = pull clock low
//   ps2_data_oe     1 = pull data low
module keyboard_tx
    import keyboard_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       send,
    input  logic [7:0] cmd,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    // Phase counter covers 0..INHIBIT_CYCLES-1 and also the 2-cycle REQ window.
    localparam int unsigned PhW = ($clog2(INHIBIT_CYCLES) < 1) ? 1 : $clog2(INHIBIT_CYCLES);
    localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

    logic clk_level;
    logic clk_fall;
    logic data_level;
    logic unused_data_fall;

    tx_state_t      state_q, state_d;
    logic [9:0]     shift_q, shift_d;
    logic [3:0]     bitcnt_q, bitcnt_d;
    logic [PhW-1:0] phase_q, phase_d;
    logic [ToW-1:0] tmo_q, tmo_d;
    logic           data_oe_q, data_oe_d;
    logic           ack_err_q, ack_err_d;

    ps2_sync u_clk_sync (
        .clock  (clock),
        .resetn (resetn),
        .pin    (ps2_clk_in),
        .level  (clk_level),
        .fall   (clk_fall)
    );

    ps2_sync u_data_sync (
        .clock  (clock),
        .resetn (resetn),
        .pin    (ps2_data_in),
        .level  (data_level),
        .fall   (unused_data_fall)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bitcnt_q  <= '0;
            phase_q   <= '0;
            tmo_q     <= '0;
            data_oe_q <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bitcnt_q  <= bitcnt_d;
            phase_q   <= phase_d;
            tmo_q     <= tmo_d;
            data_oe_q <= data_oe_d;
            ack_err_q <= ack_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bitcnt_d  = bitcnt_q;
        phase_d   = phase_q;
        tmo_d     = tmo_q;
        data_oe_d = data_oe_q;
        ack_err_d = ack_err_q;

        unique case (state_q)
            StIdle: begin
                if (send) begin
                    shift_d   = {1'b1, odd_parity(cmd), cmd};
                    phase_d   = '0;
                    bitcnt_d  = '0;
                    tmo_d     = '0;
                    data_oe_d = 1'b0;
                    ack_err_d = 1'b0;
                    state_d   = StInhibit;
                end
            end

            StInhibit: begin
                if (phase_q == PhW'(INHIBIT_CYCLES - 1)) begin
                    phase_d   = '0;
                    data_oe_d = 1'b1;  // start bit
                    state_d   = StReq;
                end else begin
                    phase_d = phase_q + PhW'(1);
                end
            end

            StReq: begin
                if (phase_q == PhW'(1)) begin
                    bitcnt_d = '0;
                    tmo_d    = '0;
                    state_d  = StShift;  // start bit stays driven until the first fall
                end else begin
                    phase_d = phase_q + PhW'(1);
                end
            end

            StShift: begin
                tmo_d = tmo_q + ToW'(1);
                if (clk_fall) begin
                    data_oe_d = ~shift_q[bitcnt_q];
                    bitcnt_d  = bitcnt_q + 4'd1;
                    if (bitcnt_q == TX_LAST_BIT) begin
                        state_d = StAck;
                    end
                end
            end

            StAck: begin
                tmo_d = tmo_q + ToW'(1);
                if (clk_fall) begin
                    ack_err_d = data_level;  // device pulls data low to acknowledge
                    state_d   = StWaitIdle;
                end
            end

            StWaitIdle: begin
                tmo_d = tmo_q + ToW'(1);
                if (clk_level && data_level) begin
                    state_d = StDone;
                end
            end

            StDone: begin
                data_oe_d = 1'b0;
                state_d   = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Device stopped clocking or never released the bus: give up and release.
        if ((state_q inside {StShift, StAck, StWaitIdle}) &&
            (tmo_q == ToW'(TIMEOUT_CYCLES))) begin
            data_oe_d = 1'b0;
            ack_err_d = 1'b1;
            state_d   = StDone;
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign ack_err     = (state_q == StDone) & ack_err_q;
    assign ps2_clk_oe  = (state_q == StInhibit) || (state_q == StReq);
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_keyboard_tx.sv
// Directed bench for keyboard_tx with a simple open-drain PS/2 device model.
`timescale 1ns/1ps
module tb_keyboard_tx;
    import keyboard_pkg::*;

    localparam int unsigned INH  = 20;
    localparam int unsigned TMO  = 400;
    localparam int unsigned HALF = 10;  // device clock half period, system cycles

    logic       clock  = 1'b0;
    logic       resetn = 1'b0;
    logic       send   = 1'b0;
    logic [7:0] cmd    = 8'h00;
    logic       busy, done, ack_err, clk_oe, data_oe;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_in, ps2_data_in;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Wired-AND bus: either side can pull a line low.
    assign ps2_clk_in  = dev_clk & ~clk_oe;
    assign ps2_data_in = dev_data & ~data_oe;

    always #5 clock = ~clock;

    keyboard_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .send        (send),
        .cmd         (cmd),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (clk_oe),
        .ps2_data_oe (data_oe)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        if (obs === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Issue send, then measure the inhibit + request-to-send window.
    // With poke set, a second send with a different byte is pulsed mid-inhibit.
    task automatic host_req(input logic [7:0] c, input bit poke);
        int hi  = 0;
        int dhi = 0;
        cmd  = c;
        send = 1'b1;
        @(negedge clock);
        send = 1'b0;
        check("busy_after_send", busy, 1);
        check("clk_oe_after_send", clk_oe, 1);
        while (clk_oe && hi < 1000) begin
            hi++;
            if (data_oe) dhi++;
            if (poke && hi == 5) begin
                send = 1'b1;
                cmd  = 8'h5A;
            end
            if (poke && hi == 6) send = 1'b0;
            @(negedge clock);
        end
        check("clk_oe_cycles", hi, INH + 2);
        check("rts_cycles", dhi, 2);
    endtask

    task automatic wait_done(input logic want_err);
        int n = 0;
        while (!done && n < int'(TMO) + 100) begin
            @(negedge clock);
            n++;
        end
        check("done_seen", done, 1);
        check("ack_err", ack_err, want_err);
        check("busy_in_done", busy, 1);
        check("oe_in_done", {clk_oe, data_oe}, 0);
        @(negedge clock);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
    endtask

    // Device side of one frame: clocks 10 bits in, then the ACK edge.
    task automatic dev_frame(input logic [7:0] c, input logic par, input bit do_ack);
        logic [9:0] got;
        logic [9:0] want;
        want = {1'b1, par, c};
        got  = '0;
        cyc(5);
        check("start_bit", ps2_data_in, 0);
        for (int i = 0; i < 10; i++) begin
            dev_clk = 1'b0;
            cyc(HALF);
            dev_clk = 1'b1;
            got[i]  = ps2_data_in;  // device samples on the rising edge
            cyc(HALF);
        end
        check("frame_bits", got, want);
        dev_data = do_ack ? 1'b0 : 1'b1;
        dev_clk  = 1'b0;
        cyc(HALF);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        wait_done(do_ack ? 1'b0 : 1'b1);
    endtask

    initial begin
        cyc(3);
        check("rst_outputs", {busy, done, ack_err, clk_oe, data_oe}, 0);
        resetn = 1'b1;
        cyc(2);
        check("idle_outputs", {busy, done, ack_err, clk_oe, data_oe}, 0);

        // ED: six ones -> parity 1
        host_req(CMD_SET_LEDS, 1'b0);
        dev_frame(CMD_SET_LEDS, 1'b1, 1'b1);
        // FF: eight ones -> parity 1
        host_req(CMD_RESET, 1'b0);
        dev_frame(CMD_RESET, 1'b1, 1'b1);
        // 00: zero ones -> parity 1
        host_req(8'h00, 1'b0);
        dev_frame(8'h00, 1'b1, 1'b1);
        // 01: one one -> parity 0
        host_req(8'h01, 1'b0);
        dev_frame(8'h01, 1'b0, 1'b1);

        // Device leaves data high at the ACK edge.
        host_req(CMD_ECHO, 1'b0);
        dev_frame(CMD_ECHO, 1'b1, 1'b0);

        // Device never clocks.
        host_req(8'h01, 1'b0);
        wait_done(1'b1);

        // Reset at the 5th device falling edge.
        host_req(CMD_SET_LEDS, 1'b0);
        cyc(5);
        for (int i = 0; i < 5; i++) begin
            dev_clk = 1'b0;
            if (i == 4) break;
            cyc(HALF);
            dev_clk = 1'b1;
            cyc(HALF);
        end
        check("busy_before_rst", busy, 1);
        resetn = 1'b0;
        @(negedge clock);
        check("midframe_rst_outputs", {busy, done, ack_err, clk_oe, data_oe}, 0);
        dev_clk = 1'b1;
        cyc(2);
        resetn = 1'b1;
        cyc(5);
        // EE: six ones -> parity 1
        host_req(CMD_ECHO, 1'b0);
        dev_frame(CMD_ECHO, 1'b1, 1'b1);

        // send pulsed while busy with another byte must not disturb the frame.
        host_req(8'h01, 1'b1);
        dev_frame(8'h01, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keyboard_tx.md
# keyboard_tx

Host-to-device PS/2 transmitter: the transmit counterpart to the keyboard scan-code receiver on the same two-wire bus. It sends one command byte to the keyboard, such as LED set, echo or reset. It generates the request-to-send sequence, clocks out data, parity and stop bits on device-generated clock edges, checks the device ACK, and reports completion or error to the typer control logic.

## Interface
Parameters:
- INHIBIT_CYCLES, 6000, system cycles PS/2 clock is held low before request-to-send (120 us at 50 MHz)
- TIMEOUT_CYCLES, 1000000, max system cycles from clock release to ACK (20 ms at 50 MHz)

Ports:
- clock  in  1  system clock; all logic on posedge clock
- resetn  in  1  synchronous, active-low reset
- send  in  1  start request, sampled only in IDLE
- cmd  in  8  command byte, latched when send accepted
- busy  out  1  transfer in progress; receiver ignores bus while high
- done  out  1  one-cycle completion pulse
- ack_err  out  1  valid with done; 1 = no ACK or timeout
- ps2_clk_in  in  1  raw PS/2 clock pin
- ps2_data_in  in  1  raw PS/2 data pin
- ps2_clk_oe  out  1  1 = pad drives clock low; 0 = released
- ps2_data_oe  out  1  1 = pad drives data low; 0 = released

## Operation
- Both pin inputs pass through a 2-flop synchronizer. A falling edge is detected when the previous synchronized sample is 1 and the current one is 0.
- The state machine has these states: IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE, DONE.
- IDLE: all outputs 0. On send=1, latch cmd and compute parity = ~^cmd (odd parity). Load shift = {1'b1, parity, cmd}, LSB first. Go to INHIBIT.
- INHIBIT: clk_oe=1, data_oe=0 for INHIBIT_CYCLES cycles, then go to REQ.
- REQ: clk_oe=1, data_oe=1 (start bit 0) for 2 cycles. Then release the clock (clk_oe=0), clear bitcnt and timeout counter, and go to SHIFT.
- SHIFT: on each synchronized falling edge, data_oe = ~shift[bitcnt] and bitcnt increments.
  - Edges 1–8 present data bits 0–7.
  - Edge 9 presents parity.
  - Edge 10 presents the stop bit (data_oe=0, line released); go to ACK.
- ACK: on the next falling edge, sample ps2_data. 0 means ACK OK; 1 means ack_err is set. Go to WAIT_IDLE.
- WAIT_IDLE: wait until synchronized clock and data are both 1, then go to DONE.
- DONE: done=1 for one cycle with ack_err valid, then IDLE.
- Timeout: the counter runs in SHIFT, ACK and WAIT_IDLE. When it reaches TIMEOUT_CYCLES, release both lines, set ack_err=1 and go to DONE.
- send while busy is ignored. cmd changes after acceptance have no effect.
- resetn=0 at any time, including mid-frame: next edge gives state IDLE, both oe=0, busy=0, done=0, ack_err=0, counters 0. The line is released at once and the device times out on its own.
- Reset values of all outputs: 0.

## Timing
- send accepted at edge N: busy=1 and clk_oe=1 from N+1.
- clk_oe stays high for exactly INHIBIT_CYCLES+2 cycles. data_oe rises for the last 2 of those cycles.
- A pin falling edge reaches the detector 3 cycles later (2 sync flops plus edge register). data_oe updates on the following edge. This is worst-case 4 cycles, well inside the roughly 30 us PS/2 low phase.
- bitcnt width is 4 bits, range 0–10, no wrap.
- done and busy: done=1 in DONE with busy still 1. busy=0 from the next cycle. A new send is accepted in the first IDLE cycle.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1). It is cleared on entry to SHIFT.

## Structure
- Package keyboard_pkg holds:
  - state enum tx_state_t
  - command constants: CMD_SET_LEDS=8'hED, CMD_ECHO=8'hEE, CMD_RESET=8'hFF
  - response constants: RSP_ACK=8'hFA, RSP_BAT_OK=8'hAA
- Sub-module ps2_sync: 2-flop synchronizer plus falling-edge detector for one line. Instantiated twice here, and reused by the receiver.
- The FSM, shift register, bit counter and timeout counter live in keyboard_tx.

## Test plan
- Send cmd=8'hED with the device model returning ACK:
  - clk_oe high for INHIBIT_CYCLES+2 cycles.
  - Device sees bits 1,0,1,1,0,1,1,1, parity 1 (ED has six 1s), then stop 1.
  - done pulse with ack_err=0, then busy falls.
- Send cmd=8'hFF (eight 1s): parity bit = 1. Send cmd=8'h00: parity bit = 1. Send cmd=8'h01: parity bit = 0. All complete with ack_err=0.
- Device model leaves data high at the ACK edge: done with ack_err=1.
- Device never clocks after REQ: after TIMEOUT_CYCLES, done with ack_err=1, and clk_oe and data_oe both 0.
- Assert resetn=0 at the 5th falling edge: next cycle all outputs 0 and state IDLE. A subsequent send of 8'hEE completes normally.
- Pulse send while busy with a different cmd: ignored, and the original byte is transmitted unchanged.
